// File: rtl/seg7_scan_counter.sv
// Decimal up/down counter with a time-multiplexed, active-low multi-digit 7-segment driver.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg7_scan_counter #(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     disp_channel,
   output logic [4*DIGITS-1:0]   value,
   output logic                  wrap
);

   localparam int unsigned CntW = $clog2(SCAN_DIV);
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

   logic [4*DIGITS-1:0] value_q, value_d, step_val;
   logic                wrap_q, wrap_d, carry;
   logic [3:0]          dig;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   disp_q, disp_d;
   logic [3:0]          cur_dig;
   logic                lz_blank;
   logic                hi_zero;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Ripple a decimal carry/borrow from digit 0 upward; carry out of the top is the wrap.
   always_comb begin
      step_val = value_q;
      carry    = 1'b1;
      dig      = 4'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         dig = value_q[4*i +: 4];
         if (carry) begin
            if (up) begin
               if (dig >= 4'd9) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = dig + 4'd1;
                  carry              = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  step_val[4*i +: 4] = 4'd9;
               end else begin
                  step_val[4*i +: 4] = dig - 4'd1;
                  carry              = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      value_d = value_q;
      wrap_d  = 1'b0;
      if (clr) begin
         value_d = '0;
      end else if (en) begin
         value_d = step_val;
         wrap_d  = carry;
      end
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CntMax) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      disp_d  = '1;
      cur_dig = 4'hf;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            disp_d[i] = 1'b0;
            cur_dig   = value_q[4*i +: 4];
         end
      end
   end

   always_comb begin
      lz_blank = 1'b0;
      hi_zero  = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      // Walk down from the top digit; digit 0 is never blanked.
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         hi_zero = hi_zero & (value_q[4*i +: 4] == 4'd0);
         if ((idx_q == IdxW'(i)) && hi_zero) begin
            lz_blank = 1'b1;
         end
      end
`else
      lz_blank = 1'b0;
      hi_zero  = 1'b0;
`endif
      seg_d = lz_blank ? 7'b1111111 : decode(cur_dig);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 7'b1111111;
         disp_q  <= '1;
      end else begin
         value_q <= value_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         disp_q  <= disp_d;
      end
   end

   assign value        = value_q;
   assign wrap         = wrap_q;
   assign seg          = seg_q;
   assign disp_channel = disp_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Bench for seg7_scan_counter: two instances (2 and 3 digits, dwell 4) share stimulus and
// are compared every cycle against a decimal-integer model, plus directed literal checks.
module tb_seg7_scan_counter;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        up = 1'b1;
   logic        clr = 1'b0;
   logic [6:0]  seg_a, seg_b;
   logic [1:0]  disp_a;
   logic [2:0]  disp_b;
   logic [7:0]  value_a;
   logic [11:0] value_b;
   logic        wrap_a, wrap_b;

   int nchk = 0;
   int nerr = 0;
   bit mon_en = 1'b0;

   seg7_scan_counter #(.DIGITS(2), .SCAN_DIV(SD)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
      .seg(seg_a), .disp_channel(disp_a), .value(value_a), .wrap(wrap_a)
   );

   seg7_scan_counter #(.DIGITS(3), .SCAN_DIV(SD)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
      .seg(seg_b), .disp_channel(disp_b), .value(value_b), .wrap(wrap_b)
   );

   always #5 clk = ~clk;

   logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(input int n, input int d);
      logic [31:0] r = '0;
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((n / pow10(i)) % 10);
      return r;
   endfunction

   function automatic logic [6:0] exp_seg(input int n, input int idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx > 0 && n < pow10(idx)) return 7'b1111111;
`endif
      return segtab[(n / pow10(idx)) % 10];
   endfunction

   // Model state: counts as plain integers, scan position from edges since reset.
   int         na, nb, edges;
   logic       m_wrap_a, m_wrap_b;
   logic [6:0] m_seg_a, m_seg_b;
   logic [1:0] m_disp_a;
   logic [2:0] m_disp_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         na = 0; nb = 0; edges = 0;
         m_wrap_a = 1'b0; m_wrap_b = 1'b0;
         m_seg_a = 7'h7f; m_seg_b = 7'h7f;
         m_disp_a = '1; m_disp_b = '1;
      end else begin
         m_disp_a = '1; m_disp_a[(edges / SD) % 2] = 1'b0;
         m_disp_b = '1; m_disp_b[(edges / SD) % 3] = 1'b0;
         m_seg_a = exp_seg(na, (edges / SD) % 2);
         m_seg_b = exp_seg(nb, (edges / SD) % 3);
         edges++;
         m_wrap_a = 1'b0; m_wrap_b = 1'b0;
         if (clr) begin
            na = 0; nb = 0;
         end else if (en && up) begin
            m_wrap_a = (na == 99);  na = (na + 1) % 100;
            m_wrap_b = (nb == 999); nb = (nb + 1) % 1000;
         end else if (en) begin
            m_wrap_a = (na == 0); na = (na + 99) % 100;
            m_wrap_b = (nb == 0); nb = (nb + 999) % 1000;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("a_value", value_a, to_bcd(na, 2));
         chk("a_wrap",  wrap_a,  m_wrap_a);
         chk("a_seg",   seg_a,   m_seg_a);
         chk("a_disp",  disp_a,  m_disp_a);
         chk("b_value", value_b, to_bcd(nb, 3));
         chk("b_wrap",  wrap_b,  m_wrap_b);
         chk("b_seg",   seg_b,   m_seg_b);
         chk("b_disp",  disp_b,  m_disp_b);
      end
   end

   // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
   task automatic cyc(input logic e, input logic u, input logic c);
      en = e; up = u; clr = c;
      @(negedge clk);
   endtask

   task automatic wait_b_start(input logic [2:0] pat);
      logic [2:0] prev;
      bit found = 1'b0;
      prev = disp_b;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (disp_b == pat && prev != pat) found = 1'b1;
         prev = disp_b;
      end
      chk("b_scan_found", found, 1);
   endtask

   task automatic wait_a(input logic [1:0] pat);
      bit found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (disp_a == pat) found = 1'b1;
      end
      chk("a_scan_found", found, 1);
   endtask

   logic [6:0] lz_exp;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_seg",    seg_a,   7'b1111111);
      chk("rst_disp_a", disp_a,  2'b11);
      chk("rst_disp_b", disp_b,  3'b111);
      chk("rst_value",  value_a, 8'h00);
      chk("rst_wrap",   wrap_a,  0);
      mon_en = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_disp_a", disp_a, 2'b10);
      chk("rel_disp_b", disp_b, 3'b110);
      chk("rel_seg",    seg_a,  7'b0000001);

      repeat (9) cyc(1, 1, 0);
      chk("up_09", value_a, 8'h09);
      cyc(1, 1, 0);
      chk("up_10", value_a, 8'h10);
      cyc(1, 0, 0);
      chk("dn_09", value_a, 8'h09);

      cyc(0, 1, 1);
      repeat (98) cyc(1, 1, 0);
      chk("up_98", value_a, 8'h98);
      cyc(1, 1, 0);
      chk("up_99", value_a, 8'h99);
      chk("up_99_wrap", wrap_a, 0);
      cyc(1, 1, 0);
      chk("up_wrap_val", value_a, 8'h00);
      chk("up_wrap",     wrap_a,  1);
      chk("b_100",       value_b, 12'h100);
      chk("b_no_wrap",   wrap_b,  0);
      cyc(0, 1, 0);
      chk("wrap_drop", wrap_a, 0);

      cyc(0, 0, 1);
      cyc(1, 0, 0);
      chk("dn_wrap_val", value_a, 8'h99);
      chk("dn_wrap",     wrap_a,  1);
      chk("b_999",       value_b, 12'h999);
      chk("b_dn_wrap",   wrap_b,  1);

      cyc(1, 1, 1);
      chk("prio_val",  value_a, 8'h00);
      chk("prio_wrap", wrap_a,  0);

      cyc(1, 0, 0);
      chk("b2b_wrap1", wrap_a, 1);
      cyc(1, 1, 0);
      chk("b2b_wrap2", wrap_a, 1);
      chk("b2b_val",   value_a, 8'h00);
      cyc(0, 1, 0);
      chk("b2b_drop", wrap_a, 0);

      cyc(0, 1, 1);
      repeat (5) cyc(1, 1, 0);
      en = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz_exp = 7'b1111111;
`else
      lz_exp = 7'b0000001;
`endif
      wait_a(2'b01);
      chk("lz_left", seg_a, lz_exp);
      wait_a(2'b10);
      chk("lz_right", seg_a, 7'b0100100);

      cyc(0, 1, 1);
      repeat (123) cyc(1, 1, 0);
      en = 1'b0;
      chk("b_123", value_b, 12'h123);
      wait_b_start(3'b110);
      chk("scan_d0_seg", seg_b, 7'b0000110);
      repeat (3) cyc(0, 1, 0);
      chk("scan_d0_hold", disp_b, 3'b110);
      cyc(0, 1, 0);
      chk("scan_d1", disp_b, 3'b101);
      chk("scan_d1_seg", seg_b, 7'b0010010);
      repeat (3) cyc(0, 1, 0);
      chk("scan_d1_hold", disp_b, 3'b101);
      cyc(0, 1, 0);
      chk("scan_d2", disp_b, 3'b011);
      chk("scan_d2_seg", seg_b, 7'b1001111);
      repeat (3) cyc(0, 1, 0);
      cyc(0, 1, 0);
      chk("scan_d0_again", disp_b, 3'b110);

      cyc(0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_seg",   seg_b,   7'b1111111);
      chk("async_disp",  disp_b,  3'b111);
      chk("async_value", value_b, 12'h000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_d0", disp_b, 3'b110);
      repeat (3) cyc(0, 1, 0);
      chk("restart_hold", disp_b, 3'b110);
      cyc(0, 1, 0);
      chk("restart_d1", disp_b, 3'b101);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/seg7_scan_counter.md
# seg7_scan_counter

Parametrised decimal up/down counter with a time-multiplexed, active-low 7-segment display driver for a common-segment multi-digit display. It holds a `DIGITS`-digit BCD value, steps it on an enable strobe with decimal carry/borrow and wrap-around, and scans the digits onto one shared segment bus, driving one digit-select line at a time. It is the successor to the single-digit BCD-to-7-segment decoder and is used for 0..(10^DIGITS−1) counters on the board display.

## Interface
- `DIGITS`, 2 — number of BCD digits/display channels, 1..8.
- `SCAN_DIV`, 50000 — clock cycles each digit stays selected, ≥2.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `en`  in  1  — count strobe, one step per cycle it is high.
- `up`  in  1  — direction: 1 = increment, 0 = decrement; sampled with `en`.
- `clr`  in  1  — synchronous clear of the count value.
- `seg`  out  7  — segments {a,b,c,d,e,f,g}, active-low, registered.
- `disp_channel`  out  DIGITS  — digit selects, active-low one-hot, registered; bit 0 = rightmost (least significant) digit.
- `value`  out  4*DIGITS  — current count, packed BCD, digit 0 in bits [3:0].
- `wrap`  out  1  — one-cycle pulse on a wrap-around step.

## Operation
- Reset, asynchronous on `rst_n` low: `value`=0, `wrap`=0, scan counter=0, digit index=0, `seg`=7'b1111111, `disp_channel`=all ones (all off).
- Count, per rising edge, priority order:
  - `clr`=1: `value`<=0, `wrap`<=0; `en` ignored.
  - `en`=1, `up`=1: BCD increment; a digit at 9 becomes 0 and carries. All-9s → all-0s with `wrap`<=1.
  - `en`=1, `up`=0: BCD decrement; a digit at 0 becomes 9 and borrows. All-0s → all-9s with `wrap`<=1.
  - Otherwise `value` holds and `wrap`<=0.
- BCD digits never hold values 10..15 in normal operation.
- Scan:
  - The scan counter runs 0..SCAN_DIV−1. On the terminal count it returns to 0 and the digit index advances, wrapping from DIGITS−1 to 0.
  - `DIGITS`=1: the index stays 0.
- Output register, loaded every cycle:
  - `disp_channel` has only bit[index] low.
  - `seg` = decode(`value` digit[index]), using 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100.
  - Any code above 9 decodes to 1111111 (blank).

## Timing
- `value`/`wrap` update on the same edge that samples `en`/`clr`/`up`; 1-cycle latency.
- `seg`/`disp_channel` lag index and `value` by 1 cycle. A count change on the displayed digit appears on `seg` one cycle after `value` changes.
- First edge after reset release: `disp_channel`=…1110 showing digit 0.
- Each digit is selected for exactly `SCAN_DIV` consecutive cycles. `seg` and `disp_channel` switch on the same edge, with no cycle where two selects are low.
- Full scan period is DIGITS×SCAN_DIV cycles. Scanning is independent of `en`/`clr`.
- `en` held high steps every cycle. Back-to-back wraps produce `wrap` high on each wrap cycle only.
- `rst_n` asserted mid-scan or mid-count forces all reset values immediately, without waiting for a clock edge. After release the scan restarts at digit 0 with a full `SCAN_DIV` dwell.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined:
  - Any digit above index 0 whose value and all more significant digits are 0 is displayed blank (`seg`=1111111), while its `disp_channel` bit is still driven low.
  - Digit 0 always shows its value, so 0 displays as a single "0".
- Not defined: every digit is displayed, including leading zeros ("05").
- `value` and `wrap` are unaffected in both cases.

## Test plan
- Reset: hold `rst_n`=0, toggle clk → `seg`=1111111, `disp_channel`=2'b11, `value`=8'h00, `wrap`=0. Release → next edge `disp_channel`=2'b10, `seg`=0000001.
- Up wrap (`DIGITS`=2): from 8'h98, two `en` pulses with `up`=1 → `value` 8'h99 then 8'h00. `wrap`=1 only in the cycle after the second step. 8'h09+1 → 8'h10.
- Down wrap: from 8'h00, one `en` pulse with `up`=0 → 8'h99 with `wrap`=1. 8'h10−1 → 8'h09.
- Scan (`SCAN_DIV`=4, `DIGITS`=3): `disp_channel` sequence 110,101,011,110… with each held exactly 4 cycles. With `value`=12'h123, `seg` follows 0000110, 0010010, 1001111.
- Priority: `clr`=1 and `en`=1 together with `value`=8'h99 → `value`=8'h00, `wrap`=0.
- Macro and reset: with the macro defined, `value`=8'h05 → left digit `seg`=1111111, right `seg`=0100100; without the macro, left `seg`=0000001. Assert `rst_n` mid-dwell → outputs off immediately, and the scan restarts at digit 0 after release.
